aclock_display: RTL

- Downstream consumer of the alarm-clock core (`aclock`).
- Takes its six BCD time digits plus the Alarm and AL_ON status, and drives a 6-digit multiplexed common-anode 7-segment display.
- Provides tear-free frame snapshots, colon/armed indicators and blinking of the whole display while the alarm rings.

---
 rtl/aclock_display_pkg.sv | 80 ++++++++
 rtl/aclock_display_bcd_to_7seg.sv | 32 +++
 rtl/aclock_display.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/aclock_display_pkg.sv
// ---------------------------------------------------------------------------
// aclock_disp_pkg
// Shared constants and types for the alarm-clock display driver.
//   - Active-low 7-segment patterns, ordered {g,f,e,d,c,b,a}
//   - Active-low digit-enable constant for "all digits off"
//   - Digit-index enum (rightmost digit first), blink phase type and
//     the frame snapshot record
// ---------------------------------------------------------------------------
package aclock_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [5:0] AN_OFF    = 6'b111111;

    typedef enum logic [2:0] {
        DIG_S0,
        DIG_S1,
        DIG_M0,
        DIG_M1,
        DIG_H0,
        DIG_H1
    } dig_idx_t;

    typedef enum logic {
        PH_ON,
        PH_OFF
    } phase_t;

    // One frame's worth of time digits plus the armed flag, captured together
    // so that a frame never mixes digits from two different clock readings.
    typedef struct packed {
        logic       al_on;
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } snap_t;

    function automatic dig_idx_t dig_next(input dig_idx_t d);
        dig_idx_t n;
        case (d)
            DIG_S0:  n = DIG_S1;
            DIG_S1:  n = DIG_M0;
            DIG_M0:  n = DIG_M1;
            DIG_M1:  n = DIG_H0;
            DIG_H0:  n = DIG_H1;
            default: n = DIG_S0;
        endcase
        return n;
    endfunction

    // Active-low one-hot digit enable for a digit index.
    function automatic logic [5:0] an_sel(input dig_idx_t d);
        logic [5:0] a;
        case (d)
            DIG_S0:  a = 6'b111110;
            DIG_S1:  a = 6'b111101;
            DIG_M0:  a = 6'b111011;
            DIG_M1:  a = 6'b110111;
            DIG_H0:  a = 6'b101111;
            DIG_H1:  a = 6'b011111;
            default: a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/aclock_display_bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 show a
// dash (segment g only) so that a corrupt digit is visibly wrong.
//   bcd  in  4  BCD digit
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import aclock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/aclock_display.sv
// ---------------------------------------------------------------------------
// aclock_display
// Drives a 6-digit multiplexed common-anode 7-segment display from the
// alarm-clock core. Digits are captured once per frame, colon and armed
// indicators go out on the decimal points, and the whole display blinks
// while the alarm rings.
//   clk      in   1  system clock
//   reset    in   1  synchronous reset, active-low
//   H_in1    in   2  hour tens (BCD)
//   H_in0    in   4  hour units
//   M_in1    in   4  minute tens
//   M_in0    in   4  minute units
//   S_in1    in   4  second tens
//   S_in0    in   4  second units
//   Alarm    in   1  alarm ringing (sampled live)
//   AL_ON    in   1  alarm armed (captured with the frame)
//   an       out  6  digit enables, active-low
//   seg      out  7  {g,f,e,d,c,b,a}, active-low
//   dp       out  1  decimal point, active-low
// Parameters:
//   SCAN_DIV      clk cycles each digit is held (>= 2)
//   BLINK_FRAMES  frames per blink half-period
//   LZ_BLANK      1 = blank hour-tens digit when it is 0
// ---------------------------------------------------------------------------
module aclock_display
    import aclock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       Alarm,
    input  logic       AL_ON,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CW         = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam int             BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] scan_cnt;
    dig_idx_t      idx;
    logic [BW-1:0] blink_cnt;
    phase_t        phase;
    snap_t         snap_p0;

    dig_idx_t      idx_p1;
    phase_t        phase_p1;
    logic          vld_p1;

    logic          scan_wrap;
    logic          frame_wrap;
    logic          snap_load;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic          lz_blank;
    logic          dp_on;
    logic          disp_off;

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_wrap && (idx == DIG_H1);
    assign snap_load  = (scan_cnt == '0) && (idx == DIG_S0);

    // ---- stage p0: scan counters, frame snapshot, blink phase ----
    // idx/phase are delayed into idx_p1/phase_p1 so they line up with the
    // snapshot captured on the frame's first cycle: the output stage then
    // shows every digit of a frame, including the first, from the new capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            idx       <= DIG_S0;
            blink_cnt <= '0;
            phase     <= PH_ON;
            snap_p0   <= '0;
            idx_p1    <= DIG_S0;
            phase_p1  <= PH_ON;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
            idx_p1 <= idx;

            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= dig_next(idx);
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (snap_load) begin
                snap_p0 <= '{al_on: AL_ON,
                             h1:    {2'b00, H_in1},
                             h0:    H_in0,
                             m1:    M_in1,
                             m0:    M_in0,
                             s1:    S_in1,
                             s0:    S_in0};
            end

            // A quiet alarm parks the blink in ON so the next alarm starts lit.
            if (!Alarm) begin
                blink_cnt <= '0;
                phase     <= PH_ON;
                phase_p1  <= PH_ON;
            end else begin
                phase_p1 <= phase;
                if (frame_wrap) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx_p1)
            DIG_S0:  digit = snap_p0.s0;
            DIG_S1:  digit = snap_p0.s1;
            DIG_M0:  digit = snap_p0.m0;
            DIG_M1:  digit = snap_p0.m1;
            DIG_H0:  digit = snap_p0.h0;
            DIG_H1:  digit = snap_p0.h1;
            default: digit = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    assign lz_blank = (LZ_BLANK != 0) && (idx_p1 == DIG_H1) && (snap_p0.h1 == 4'd0);
    assign dp_on    = (idx_p1 == DIG_M0) || (idx_p1 == DIG_H0) ||
                      ((idx_p1 == DIG_S0) && snap_p0.al_on);
    // Alarm is used live here so the display comes back on the first edge
    // that sees the alarm cleared, even if phase_p1 still says OFF.
    assign disp_off = !vld_p1 || (Alarm && (phase_p1 == PH_OFF));

    // ---- stage p1: registered display outputs ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (disp_off) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_sel(idx_p1);
            seg <= lz_blank ? SEG_BLANK : seg_dec;
            dp  <= !dp_on;
        end
    end

endmodule
